aes_seq_ctrl: RTL
=================

AES_SEQ_CTRL -- requirements
Module: aes_seq_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 256: maximum RUN-state cycles allowed while waiting for CORE_DONE; used only when AES_SEQ_TIMEOUT_EN is defined.
REQ-002 Clk  in  1  clock; all state updates on rising edge.
REQ-003 Reset  in  1  reset Reset, synchronous, active-high; clock Clk.
REQ-004 START  in  1  bit 0 of start register (address 14), level-sensitive.
REQ-005 RF_ADDR  out  4  register-file word address driven by controller.
REQ-006 RF_RDATA  in  32  combinational read data of word at RF_ADDR.
REQ-007 RF_WDATA  out  32  write data to register file.
REQ-008 RF_WE  out  1  register-file write strobe, full-word write.
REQ-009 BUSY  out  1  controller owns register-file port; host writes are blocked externally while high.
REQ-010 CORE_KEY  out  128  key to AES core; word at address 0 occupies bits 127:96, address 3 bits 31:0.
REQ-011 CORE_MSG  out  128  ciphertext to AES core; address 4 maps to bits 127:96, address 7 to bits 31:0.
REQ-012 CORE_START  out  1  one-cycle start pulse to AES core.
REQ-013 CORE_DONE  in  1  core completion, sampled only in RUN.
REQ-014 CORE_RESULT  in  128  plaintext, valid in the cycle CORE_DONE is high.
REQ-015 DONE  out  1  operation complete, held until START deasserts.
REQ-016 ERROR  out  1  core timeout indication.

Function
REQ-017 States: IDLE, LOAD_KEY, LOAD_MSG, RUN, STORE, FLAG, WAIT_CLR, CLR.
- IDLE: if START=1, go to LOAD_KEY next cycle.
REQ-018 LOAD_KEY: 4 cycles, RF_ADDR = 0,1,2,3; each RF_RDATA latched into the corresponding CORE_KEY word; RF_WE=0.
REQ-019 LOAD_MSG: 4 cycles, RF_ADDR = 4..7; each word latched into CORE_MSG; RF_WE=0.
REQ-020 RUN: CORE_START=1 only in the first RUN cycle; on CORE_DONE=1, latch CORE_RESULT and go to STORE.
REQ-021 STORE: 4 cycles, RF_WE=1, RF_ADDR = 8..11, RF_WDATA = result bits 127:96, 95:64, 63:32, 31:0 in that order.
REQ-022 FLAG: 1 cycle, RF_WE=1, RF_ADDR=15, RF_WDATA=32'h1 (32'h2 on timeout); go to WAIT_CLR.
REQ-023 WAIT_CLR: DONE=1; remain while START=1; on START=0 go to CLR.
REQ-024 CLR: 1 cycle, RF_WE=1, RF_ADDR=15, RF_WDATA=0, DONE=0, ERROR=0; go to IDLE.
REQ-025 BUSY=1 in every state except IDLE and WAIT_CLR.
REQ-026 Latency: START high in IDLE at edge n gives first CORE_START at cycle n+9; core completion at cycle m gives the done-register write at cycle m+5.
REQ-027 START deasserted during LOAD_KEY through FLAG is ignored; the sequence completes.
REQ-028 CORE_DONE outside RUN, and CORE_DONE in the same cycle as CORE_START, are both accepted only in RUN; CORE_DONE in the CORE_START cycle completes RUN.
REQ-029 RF_WE=0 in IDLE, LOAD_KEY, LOAD_MSG, RUN and WAIT_CLR.

Reset
REQ-030 Reset=1 at any edge, including mid-operation, forces IDLE; no register-file writes occur in that cycle.
REQ-031 Reset values: RF_ADDR=0, RF_WDATA=0, RF_WE=0, BUSY=0, CORE_KEY=0, CORE_MSG=0, CORE_START=0, DONE=0, ERROR=0, timeout counter=0.

Configuration
REQ-032 With AES_SEQ_TIMEOUT_EN defined, a counter cleared on RUN entry increments each RUN cycle.
- If the count reaches TIMEOUT without CORE_DONE, the controller goes to FLAG, writes 32'h2, skips STORE, and sets ERROR=1 until CLR.
REQ-033 Without AES_SEQ_TIMEOUT_EN, RUN waits indefinitely, no counter is implemented, and ERROR is tied to 0.

Verification
REQ-034 Preload key 000102030405060708090a0b0c0d0e0f and message words, set START, return CORE_DONE after 10 cycles with result 00112233445566778899aabbccddeeff -> CORE_KEY matches the key, words 8..11 = 00112233/44556677/8899aabb/ccddeeff, word 15 = 1, DONE=1.
REQ-035 Hold START=1 after completion -> controller stays in WAIT_CLR with no extra CORE_START; drop START -> word 15 = 0 and DONE=0 one cycle later.
REQ-036 Assert Reset during STORE after 2 writes -> IDLE next cycle, words 10..11 unchanged, all outputs 0.
REQ-037 With the macro defined and TIMEOUT=16, CORE_DONE never asserted -> word 15 = 32'h2 16 cycles after CORE_START, ERROR=1, words 8..11 untouched.
REQ-038 Raise START at cycle 0 and pulse START low at cycle 3 -> CORE_START at cycle 9 and the sequence completes normally.

Source files
------------

// File: rtl/aes_seq_ctrl.sv
// AES decrypt sequencer: loads key/ciphertext from the register file, runs the core,
// stores the plaintext and raises the done flag. Define AES_SEQ_TIMEOUT_EN for the core timeout.
module aes_seq_ctrl #(
  parameter int TIMEOUT = 256
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         START,
  output logic [3:0]   RF_ADDR,
  input  logic [31:0]  RF_RDATA,
  output logic [31:0]  RF_WDATA,
  output logic         RF_WE,
  output logic         BUSY,
  output logic [127:0] CORE_KEY,
  output logic [127:0] CORE_MSG,
  output logic         CORE_START,
  input  logic         CORE_DONE,
  input  logic [127:0] CORE_RESULT,
  output logic         DONE,
  output logic         ERROR
);

  typedef enum logic [2:0] {
    IDLE, LOAD_KEY, LOAD_MSG, RUN, STORE, FLAG, WAIT_CLR, CLR
  } state_t;

  state_t       state;
  logic [1:0]   idx;
  logic [1:0]   idx_nxt;
  logic [127:0] result;
  logic         we_q;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("aes_seq_ctrl: TIMEOUT must be at least 1");
  end

`ifdef AES_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tmo_cnt;
  logic          err_q;
  logic          tmo_hit;
  assign tmo_hit = (tmo_cnt == CW'(TIMEOUT - 1));
  assign ERROR   = err_q;
`else
  assign ERROR = 1'b0;
`endif

  assign idx_nxt = idx + 2'd1;

  // A write strobe still high from the previous edge must not land in the reset cycle.
  assign RF_WE = we_q & ~Reset;

  // NOTE: result is pure datapath, always loaded before use, so it carries no reset.
  always_ff @(posedge Clk) begin
    if (state == RUN && CORE_DONE) result <= CORE_RESULT;
  end

  // NOTE: all state and outputs update with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      idx        <= 2'd0;
      RF_ADDR    <= 4'd0;
      RF_WDATA   <= 32'd0;
      we_q       <= 1'b0;
      BUSY       <= 1'b0;
      CORE_KEY   <= 128'd0;
      CORE_MSG   <= 128'd0;
      CORE_START <= 1'b0;
      DONE       <= 1'b0;
`ifdef AES_SEQ_TIMEOUT_EN
      tmo_cnt    <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            state   <= LOAD_KEY;
            idx     <= 2'd0;
            RF_ADDR <= 4'd0;
            BUSY    <= 1'b1;
          end
        end

        LOAD_KEY: begin
          CORE_KEY[{~idx, 5'b0} +: 32] <= RF_RDATA;
          RF_ADDR <= RF_ADDR + 4'd1;
          idx     <= idx_nxt;
          if (idx == 2'd3) state <= LOAD_MSG;
        end

        LOAD_MSG: begin
          CORE_MSG[{~idx, 5'b0} +: 32] <= RF_RDATA;
          idx <= idx_nxt;
          if (idx == 2'd3) begin
            state      <= RUN;
            CORE_START <= 1'b1;
`ifdef AES_SEQ_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
          end else begin
            RF_ADDR <= RF_ADDR + 4'd1;
          end
        end

        RUN: begin
          CORE_START <= 1'b0;
          if (CORE_DONE) begin
            state    <= STORE;
            idx      <= 2'd0;
            we_q     <= 1'b1;
            RF_ADDR  <= 4'd8;
            RF_WDATA <= CORE_RESULT[127:96];
          end
`ifdef AES_SEQ_TIMEOUT_EN
          else if (tmo_hit) begin
            state    <= FLAG;
            we_q     <= 1'b1;
            RF_ADDR  <= 4'd15;
            RF_WDATA <= 32'h2;
            err_q    <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
`endif
        end

        STORE: begin
          idx <= idx_nxt;
          if (idx == 2'd3) begin
            state    <= FLAG;
            RF_ADDR  <= 4'd15;
            RF_WDATA <= 32'h1;
          end else begin
            RF_ADDR  <= RF_ADDR + 4'd1;
            RF_WDATA <= result[{~idx_nxt, 5'b0} +: 32];
          end
        end

        FLAG: begin
          state <= WAIT_CLR;
          we_q  <= 1'b0;
          BUSY  <= 1'b0;
          DONE  <= 1'b1;
        end

        WAIT_CLR: begin
          if (!START) begin
            state    <= CLR;
            we_q     <= 1'b1;
            RF_ADDR  <= 4'd15;
            RF_WDATA <= 32'd0;
            BUSY     <= 1'b1;
            DONE     <= 1'b0;
`ifdef AES_SEQ_TIMEOUT_EN
            err_q    <= 1'b0;
`endif
          end
        end

        CLR: begin
          state   <= IDLE;
          we_q    <= 1'b0;
          BUSY    <= 1'b0;
          RF_ADDR <= 4'd0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
